// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Purpose  : Shared constants, state encoding and helper functions for the
//             carry-lookahead adder family (sequential and pipelined).
//  Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

    // Width of one carry-lookahead slice
    localparam int NIB_W = 4;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Two's-complement overflow: operands agree in sign but the sum does not
    function automatic logic ovf_term(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla4.sv
`default_nettype none
// ============================================================================
//  Module   : cla4
//  Purpose  : 4-bit carry-lookahead adder slice with group propagate and
//             group generate outputs for hierarchical lookahead.
//  Revision : 1.0  initial release
// ============================================================================
module cla4
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             ci_i,
    output logic [NIB_W-1:0] s_o,
    output logic             co_o,
    output logic             pg_o,
    output logic             gg_o
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W-1:0] w_c;

    // Bit generate/propagate and fully expanded lookahead carries
    always_comb begin
        w_g    = a_i & b_i;
        w_p    = a_i ^ b_i;
        w_c[0] = ci_i;
        w_c[1] = w_g[0] | (w_p[0] & ci_i);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci_i);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & ci_i);
        pg_o   = &w_p;
        gg_o   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        co_o   = gg_o | (pg_o & ci_i);
        s_o    = w_p ^ w_c;
    end

endmodule : cla4
`default_nettype wire

// File: rtl/cla_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_seq_adder
//  Purpose  : WIDTH-bit adder that reuses one CLA4 slice, one nibble per cycle
//             LSB first, with valid/ready handshakes on input and output.
//  Revision : 1.0  initial release
// ============================================================================
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             OV
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NNIB - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] nib_cnt_q, nib_cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [NIB_W-1:0] w_nib_s;
    logic             w_nib_co;
    logic [1:0]       w_unused_pg_gg;
    logic             w_accept;
    logic             w_last;

    // The single shared nibble datapath
    cla4 u_cla4 (
        .a_i  (a_q[NIB_W-1:0]),
        .b_i  (b_q[NIB_W-1:0]),
        .ci_i (carry_q),
        .s_o  (w_nib_s),
        .co_o (w_nib_co),
        .pg_o (w_unused_pg_gg[0]),
        .gg_o (w_unused_pg_gg[1])
    );

    assign w_accept = in_valid && (state_q == ST_IDLE);
    assign w_last   = (nib_cnt_q == C_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept)  state_d = ST_RUN;
            ST_RUN:  if (w_last)    state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes are pure decodes of the state
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath next state: latch on accept, shift one nibble per RUN cycle
    always_comb begin
        nib_cnt_d = nib_cnt_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        co_d      = co_q;
        ov_d      = ov_q;
        if (w_accept) begin
            a_d       = A;
            b_d       = B;
            carry_d   = Ci;
            a_msb_d   = A[WIDTH-1];
            b_msb_d   = B[WIDTH-1];
            nib_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            // Sum enters at the top so after NNIB shifts nibble 0 sits at the bottom
            res_d     = {w_nib_s, res_q[WIDTH-1:NIB_W]};
            a_d       = a_q >> NIB_W;
            b_d       = b_q >> NIB_W;
            carry_d   = w_nib_co;
            nib_cnt_d = nib_cnt_q + CNT_W'(1);
            if (w_last) begin
                co_d = w_nib_co;
                ov_d = ovf_term(a_msb_q, b_msb_q, w_nib_s[NIB_W-1]);
            end
        end
    end

    // Datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_cnt_q <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            co_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            nib_cnt_q <= nib_cnt_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            co_q      <= co_d;
            ov_q      <= ov_d;
        end
    end

    assign S  = res_q;
    assign Co = co_q;
    assign OV = ov_q;

endmodule : cla_seq_adder
`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_seq_adder
//  Purpose  : Directed self-checking bench for cla_seq_adder (WIDTH=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla_seq_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Co;
    logic         OV;

    int checks = 0;
    int errors = 0;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Ci        (Ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Co        (Co),
        .OV        (OV)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set, then scramble the inputs to prove they are latched
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        A = a; B = b; Ci = ci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        A = ~a; B = ~b; Ci = ~ci;
    endtask

    // Count cycles until out_valid (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Ci = 1'b0;
        step(); step();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (S !== 16'h0000)     begin errors++; $display("FAIL reset_S got=%h exp=0000", S); end
        checks++; if (Co !== 1'b0 || OV !== 1'b0) begin errors++; $display("FAIL reset_Co_OV got=%b%b exp=00", Co, OV); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_carry_chain();
        int n;
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_valid(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL carry_latency got=%0d exp=4", n); end
        checks++; if (S !== 16'h0000 || Co !== 1'b1 || OV !== 1'b0)
            begin errors++; $display("FAIL carry_chain got S=%h Co=%b OV=%b exp S=0000 Co=1 OV=0", S, Co, OV); end
        release_result();
    endtask

    task automatic test_overflow();
        logic [W-1:0] va [2] = '{16'h7FFF, 16'h8000};
        logic [W-1:0] vb [2] = '{16'h0001, 16'h8000};
        logic [W-1:0] es [2] = '{16'h8000, 16'h0000};
        logic         ec [2] = '{1'b0, 1'b1};
        int n;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], 1'b0);
            wait_valid(n);
            checks++; if (n !== 4 || S !== es[i] || Co !== ec[i] || OV !== 1'b1)
                begin errors++; $display("FAIL overflow_%0d got n=%0d S=%h Co=%b OV=%b exp n=4 S=%h Co=%b OV=1", i, n, S, Co, OV, es[i], ec[i]); end
            release_result();
        end
    endtask

    task automatic test_carry_in();
        logic [W-1:0] va [2] = '{16'h1234, 16'h0FFF};
        logic [W-1:0] vb [2] = '{16'h4321, 16'h0001};
        logic         vc [2] = '{1'b1, 1'b0};
        logic [W-1:0] es [2] = '{16'h5556, 16'h1000};
        int n;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], vc[i]);
            wait_valid(n);
            checks++; if (n !== 4 || S !== es[i] || Co !== 1'b0 || OV !== 1'b0)
                begin errors++; $display("FAIL carry_in_%0d got n=%0d S=%h Co=%b OV=%b exp n=4 S=%h Co=0 OV=0", i, n, S, Co, OV, es[i]); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int n;
        start_op(16'h9111, 16'hA222, 1'b0);   // 0x13333 -> S=3333 Co=1 OV=1
        wait_valid(n);
        for (int k = 0; k < 5; k++) begin
            A = 16'h0100 * k[15:0]; B = 16'hFFFF; Ci = k[0]; in_valid = k[0];
            step();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || S !== 16'h3333 || Co !== 1'b1 || OV !== 1'b1)
                begin errors++; $display("FAIL backpressure_%0d got ov=%b ir=%b S=%h Co=%b OV=%b exp ov=1 ir=0 S=3333 Co=1 OV=1",
                                         k, out_valid, in_ready, S, Co, OV); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL backpressure_release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        step(); step();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || S !== 16'h0000 || Co !== 1'b0 || OV !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_mid_run got ov=%b S=%h Co=%b OV=%b ir=%b exp ov=0 S=0000 Co=0 OV=0 ir=1",
                                     out_valid, S, Co, OV, in_ready); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard got ov=%b exp=0", out_valid); end
        start_op(16'h0003, 16'h0005, 1'b1);
        wait_valid(n);
        checks++; if (n !== 4 || S !== 16'h0009 || Co !== 1'b0 || OV !== 1'b0)
            begin errors++; $display("FAIL reset_recover got n=%0d S=%h Co=%b OV=%b exp n=4 S=0009 Co=0 OV=0", n, S, Co, OV); end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [4] = '{16'h0001, 16'hABCD, 16'hFFFF, 16'h5000};
        logic [W-1:0] vb [4] = '{16'h0002, 16'h1111, 16'hFFFF, 16'h3000};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] es [4] = '{16'h0003, 16'hBCDE, 16'hFFFF, 16'h8000};
        logic         ec [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic         eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int n_acc = 0;
        int n_res = 0;
        int last  = 0;
        int cyc   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (n_res < 4 && cyc < 80) begin
            if (out_valid) begin
                checks++; if (S !== es[n_res] || Co !== ec[n_res] || OV !== eo[n_res])
                    begin errors++; $display("FAIL b2b_result_%0d got S=%h Co=%b OV=%b exp S=%h Co=%b OV=%b",
                                             n_res, S, Co, OV, es[n_res], ec[n_res], eo[n_res]); end
                n_res++;
            end
            if (in_ready) begin
                if (n_acc < 4) begin
                    A = va[n_acc]; B = vb[n_acc]; Ci = vc[n_acc]; in_valid = 1'b1;
                    if (n_acc > 0) begin
                        checks++; if (cyc - last !== 6)
                            begin errors++; $display("FAIL b2b_spacing_%0d got=%0d exp=6", n_acc, cyc - last); end
                    end
                    last = cyc;
                    n_acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (n_res !== 4 || n_acc !== 4)
            begin errors++; $display("FAIL b2b_count got acc=%0d res=%0d exp acc=4 res=4", n_acc, n_res); end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_overflow();
        test_carry_in();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cla_seq_adder
`default_nettype wire

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder controller that time-shares a single 4-bit carry-lookahead slice (CLA4) to add WIDTH-bit operands one nibble per cycle, LSB first, with the carry held in a register between nibbles. Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Provides an area-minimal alternative to a full-width CLA tree where throughput is not critical.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4 and at least 8.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set is valid.
- in_ready  out  1  controller can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Ci  in  1  carry-in to nibble 0.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  sum.
- Co  out  1  carry-out of the MSB nibble.
- OV  out  1  two's-complement signed overflow.

## Operation
- NNIB = WIDTH/4. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. An accept (in_valid && in_ready) latches A, B, Ci into the operand shift registers and the carry register, clears nib_cnt, and sets state to RUN.
- RUN: the CLA4 input is the low nibble of the A/B shift registers plus the carry register. On each edge:
  - the CLA4 sum shifts into the top of the result register;
  - the operands shift right by 4;
  - the carry register loads CLA4 Co;
  - nib_cnt increments.
- On the edge where nib_cnt == NNIB-1:
  - Co loads the CLA4 Co;
  - OV loads (A_msb == B_msb) && (sum_msb != A_msb), using the latched operand MSBs;
  - state goes to DONE.
- DONE: out_valid=1; S/Co/OV are held stable. On out_ready, state goes to IDLE.
- in_ready is combinational: (state == IDLE). It is 0 in RUN and DONE. in_valid is ignored outside IDLE.
- Input changes on A/B/Ci after an accept have no effect on the operation in flight.
- CLA4 PG/GG outputs are unused.
- nib_cnt is $clog2(NNIB) bits wide. It is never compared beyond NNIB-1 and resets to 0 on entering RUN.
- Reset (asserted at any time, including mid-RUN or in DONE):
  - state goes to IDLE;
  - nib_cnt, carry, operand and result registers clear to 0;
  - the in-flight operation is discarded and no out_valid is produced for it.

## Timing
- Reset values: in_ready=1, out_valid=0, S=0, Co=0, OV=0.
- Accept at edge T0. Nibbles are computed at edges T1..TNNIB. out_valid is high from TNNIB (after that edge) until the edge where out_ready=1 is sampled.
- Latency from accept to out_valid is NNIB cycles (4 for WIDTH=16).
- Minimum spacing between accepts is NNIB+2 cycles: RUN, then DONE with out_ready=1 in the same cycle, then IDLE.
- out_ready=1 before out_valid has no effect. Backpressure may last indefinitely; outputs are held stable throughout.
- S reflects the partially shifted result during RUN. It is defined only while out_valid=1.
- A deasserted rst_n release is synchronised by the instantiating logic; the first accept is possible on the first edge after release.

## Structure
- Package cla_pkg:
  - NIB_W=4;
  - state encoding localparams ST_IDLE/ST_RUN/ST_DONE (2-bit);
  - a function for the overflow term, shared with the future pipelined adder.
- One sub-module: the existing CLA4, instantiated exactly once as the shared nibble datapath.
- The controller holds the FSM, nib_cnt, the carry flop, the operand/result shift registers and the output registers.

## Test plan
All scenarios use WIDTH=16.
- Carry chain: A=0xFFFF, B=0x0001, Ci=0 -> S=0x0000, Co=1, OV=0; out_valid exactly 4 cycles after accept.
- Signed overflow: A=0x7FFF, B=0x0001, Ci=0 -> S=0x8000, Co=0, OV=1. Second case: A=0x8000, B=0x8000 -> S=0x0000, Co=1, OV=1.
- Carry-in: A=0x1234, B=0x4321, Ci=1 -> S=0x5556, Co=0, OV=0. Second case: A=0x0FFF, B=0x0001, Ci=0 -> S=0x1000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggle A/B and pulse in_valid -> S/Co/OV stable, in_ready=0, no second accept. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 two cycles after accept -> immediately out_valid=0, S=0, Co=0, OV=0, in_ready=1. After release, A=0x0003, B=0x0005, Ci=1 -> S=0x0009.
- Back-to-back: in_valid held high with out_ready=1 -> accepts exactly every 6 cycles, and each result matches the reference sum.
